// File: rtl/cell_mon_pkg.sv
// cell_mon_pkg: shared types and defaults for the cell toggle monitor.
//   mon_state_e : measurement FSM states
//   CNT_W_DEF   : default result counter width
//   WIN_W_DEF   : default window-length width
package cell_mon_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int WIN_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM    = 2'd1,
      COUNT  = 2'd2,
      REPORT = 2'd3
   } mon_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   gclk, grst_n : clock, async active-low reset
//   clr          : synchronous clear (wins over inc)
//   inc          : count enable
//   q            : current count
//   at_max       : q is all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         gclk,
   input  logic         grst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q,
   output logic         at_max
);

   assign at_max = &q;

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n)              q <= '0;
      else if (clr)             q <= '0;
      else if (inc && !at_max)  q <= q + 1'b1;
   end

endmodule

// File: rtl/cell_toggle_monitor.sv
// cell_toggle_monitor: counts rising edges, falling edges and high cycles of
// a monitored cell output over a programmed window of sample cycles.
//   CLK, RSTB        : clock, async active-low reset
//   START            : begin a measurement (accepted in IDLE only)
//   ABORT            : cancel an active measurement (ARM/COUNT)
//   WINDOW           : sample count, latched when START is accepted
//   Q_IN             : monitored signal, synchronous to CLK
//   BUSY             : high in ARM and COUNT
//   DONE             : one-cycle pulse in REPORT
//   RISE/FALL/HIGH_CNT : saturating activity counts
//   SAT              : some counter reached all-ones this measurement
module cell_toggle_monitor
   import cell_mon_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic             CLK,
   input  logic             RSTB,
   input  logic             START,
   input  logic             ABORT,
   input  logic [WIN_W-1:0] WINDOW,
   input  logic             Q_IN,
   output logic             BUSY,
   output logic             DONE,
   output logic [CNT_W-1:0] RISE_CNT,
   output logic [CNT_W-1:0] FALL_CNT,
   output logic [CNT_W-1:0] HIGH_CNT,
   output logic             SAT
);

   localparam int NCNT = 3;

   mon_state_e                 state, nxt;
   logic       [WIN_W-1:0]     remaining;
   logic                       prev;
   logic                       start_acc;
   logic                       sample;
   logic       [NCNT-1:0]      inc;
   logic       [NCNT-1:0]      at_max;
   logic [NCNT-1:0][CNT_W-1:0] cnt;

   assign start_acc = (state == IDLE) && START;
   assign sample    = (state == COUNT);

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) state <= IDLE;
      else       state <= nxt;
   end

   // ABORT is checked ahead of the window-end test so it wins a tie.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (START) nxt = ARM;
         ARM: begin
            if (ABORT)                   nxt = IDLE;
            else if (remaining == '0)    nxt = REPORT;
            else                         nxt = COUNT;
         end
         COUNT: begin
            if (ABORT)                         nxt = IDLE;
            else if (remaining == WIN_W'(1))   nxt = REPORT;
         end
         REPORT:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Window is latched on START acceptance so ARM can already see a zero
   // window; the baseline is the Q_IN value seen during ARM itself.
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         remaining <= '0;
         prev      <= 1'b0;
      end else begin
         if (start_acc)              remaining <= WINDOW;
         else if (sample)            remaining <= remaining - 1'b1;
         if (state == ARM || sample) prev      <= Q_IN;
      end
   end

   // The abort cycle's sample is still counted; counts freeze after it.
   assign inc[0] = sample && !prev &&  Q_IN;
   assign inc[1] = sample &&  prev && !Q_IN;
   assign inc[2] = sample &&  Q_IN;

   for (genvar g = 0; g < NCNT; g++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
         .gclk   (CLK),
         .grst_n (RSTB),
         .clr    (start_acc),
         .inc    (inc[g]),
         .q      (cnt[g]),
         .at_max (at_max[g])
      );
   end

   assign RISE_CNT = cnt[0];
   assign FALL_CNT = cnt[1];
   assign HIGH_CNT = cnt[2];
   // Counters only clear on START, so any at_max stays visible until then.
   assign SAT      = |at_max;
   assign BUSY     = (state == ARM) || (state == COUNT);
   assign DONE     = (state == REPORT);

endmodule
